// File: rtl/burst_detect_pkg.sv
// rtl/burst_detect_pkg.sv - shared delay-line constants and burst FSM encodings
package burst_detect_pkg;

  localparam int CLK_FREQ             = 81_000_000;
  localparam int MODULATION_FREQ      = 13_500_000;
  localparam int DFLT_CLKS_PER_PERIOD = CLK_FREQ / MODULATION_FREQ;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUALIFY = 2'd1,
    S_ACTIVE  = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

endpackage

// File: rtl/burst_detect_if.sv
// rtl/burst_detect_if.sv - carrier input and burst envelope outputs of the detector
interface burst_detect_if #(
  parameter int MAX_BURST = 162
);
  localparam int LEN_WIDTH = $clog2(MAX_BURST + 1);

  logic                 in;
  logic                 envelope;
  logic                 burst_start;
  logic                 burst_end;
  logic                 overlength;
  logic [LEN_WIDTH-1:0] burst_len;

  modport master (
    output in,
    input  envelope, burst_start, burst_end, overlength, burst_len
  );

  modport slave (
    input  in,
    output envelope, burst_start, burst_end, overlength, burst_len
  );
endinterface

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - two-flop synchroniser for an asynchronous single-bit input
module sync_ff (
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/burst_detect.sv
// rtl/burst_detect.sv - qualifies modulated-carrier bursts and produces a registered envelope
module burst_detect #(
  parameter int CLKS_PER_PERIOD = burst_detect_pkg::DFLT_CLKS_PER_PERIOD,
  parameter int MIN_EDGES       = 4,
  parameter int GAP_TIMEOUT     = 9,
  parameter int MAX_BURST       = 162,
  parameter int HOLDOFF         = 12,
  localparam int LEN_WIDTH      = $clog2(MAX_BURST + 1)
) (
  input  logic           clk,
  input  logic           n_reset,
  burst_detect_if.slave  bus
);
  import burst_detect_pkg::*;

  // A gap shorter than one carrier period would chop every burst, so clamp it.
  localparam int GAP_EFF = (GAP_TIMEOUT > CLKS_PER_PERIOD) ? GAP_TIMEOUT : CLKS_PER_PERIOD + 1;
  localparam int GW      = $clog2(GAP_EFF + 1);
  localparam int EW      = $clog2(MIN_EDGES + 1);
  localparam int HW      = $clog2(HOLDOFF + 1);

  // Decision is taken one clock early so the registered fall lands GAP_EFF after the strobe.
  localparam logic [GW-1:0]        GAP_LAST  = GW'(GAP_EFF - 2);
  localparam logic [GW-1:0]        GAP_SAT   = GW'(GAP_EFF);
  localparam logic [EW-1:0]        EDGE_LAST = EW'(MIN_EDGES - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_MAX   = LEN_WIDTH'(MAX_BURST);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLDOFF - 1);

  logic in_sync, in_prev, strobe, timeout;

  state_t               state, state_nxt;
  logic [EW-1:0]        edge_cnt, edge_nxt;
  logic [GW-1:0]        gap_ctr, gap_nxt;
  logic [LEN_WIDTH-1:0] len_ctr, len_nxt;
  logic [HW-1:0]        hold_ctr, hold_nxt;
  logic                 env_q, env_nxt;
  logic                 start_q, start_nxt;
  logic                 end_q, end_nxt;
  logic                 ovl_q, ovl_nxt;
  logic [LEN_WIDTH-1:0] blen_q, blen_nxt;

  sync_ff u_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (bus.in),
    .q       (in_sync)
  );

  assign strobe  = in_sync & ~in_prev;
  assign timeout = ~strobe && (gap_ctr == GAP_LAST);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      in_prev  <= 1'b0;
      state    <= S_IDLE;
      edge_cnt <= '0;
      gap_ctr  <= '0;
      len_ctr  <= '0;
      hold_ctr <= '0;
      env_q    <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      ovl_q    <= 1'b0;
      blen_q   <= '0;
    end else begin
      in_prev  <= in_sync;
      state    <= state_nxt;
      edge_cnt <= edge_nxt;
      gap_ctr  <= gap_nxt;
      len_ctr  <= len_nxt;
      hold_ctr <= hold_nxt;
      env_q    <= env_nxt;
      start_q  <= start_nxt;
      end_q    <= end_nxt;
      ovl_q    <= ovl_nxt;
      blen_q   <= blen_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    edge_nxt  = edge_cnt;
    len_nxt   = len_ctr;
    hold_nxt  = hold_ctr;
    start_nxt = 1'b0;
    end_nxt   = 1'b0;
    ovl_nxt   = 1'b0;
    blen_nxt  = blen_q;
    if (strobe)
      gap_nxt = '0;
    else if (gap_ctr == GAP_SAT)
      gap_nxt = gap_ctr;
    else
      gap_nxt = gap_ctr + GW'(1);

    case (state)
      S_IDLE: begin
        if (strobe) begin
          state_nxt = S_QUALIFY;
          edge_nxt  = EW'(1);
        end
      end
      S_QUALIFY: begin
        if (strobe) begin
          edge_nxt = edge_cnt + EW'(1);
          if (edge_cnt == EDGE_LAST) begin
            state_nxt = S_ACTIVE;
            start_nxt = 1'b1;
            len_nxt   = LEN_WIDTH'(1);
          end
        end else if (timeout) begin
          state_nxt = S_IDLE;
        end
      end
      S_ACTIVE: begin
        // Length cut is checked first so it wins over a coincident timeout.
        if (len_ctr == LEN_MAX) begin
          state_nxt = S_HOLDOFF;
          end_nxt   = 1'b1;
          ovl_nxt   = 1'b1;
          blen_nxt  = len_ctr;
          hold_nxt  = '0;
        end else if (timeout) begin
          state_nxt = S_HOLDOFF;
          end_nxt   = 1'b1;
          blen_nxt  = len_ctr;
          hold_nxt  = '0;
        end else begin
          len_nxt = len_ctr + LEN_WIDTH'(1);
        end
      end
      S_HOLDOFF: begin
        if (hold_ctr == HOLD_LAST)
          state_nxt = S_IDLE;
        else
          hold_nxt = hold_ctr + HW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase

    env_nxt = (state_nxt == S_ACTIVE);
  end

  assign bus.envelope    = env_q;
  assign bus.burst_start = start_q;
  assign bus.burst_end   = end_q;
  assign bus.overlength  = ovl_q;
  assign bus.burst_len   = blen_q;

endmodule

// File: tb/tb_burst_detect.sv
// tb/tb_burst_detect.sv - directed scenario bench for burst_detect
module tb_burst_detect;
  import burst_detect_pkg::*;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  burst_detect_if #(.MAX_BURST(162)) bus ();

  burst_detect dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int start_q[$];
  int end_q[$];
  int len_q[$];
  int ovl_q[$];
  int env_first;
  bit st8_idle, st9_idle, quiet_after_rst;
  int rst_env, rst_start, rst_end, rst_ovl, rst_len;

  function automatic int get(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Carrier of n periods (6 clocks, 3 high) whose first strobe lands at cycle s.
  function automatic bit seg_on(input int k, input int s, input int n);
    int r;
    r = k - s + 2;
    return (n > 0) && (r >= 0) && (r < 6 * n) && ((r % 6) < 3);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_scn(input int s0, input int n0, input int s1, input int n1,
                         input int s2, input int n2, input int reset_at,
                         input bit glitch, input int last);
    start_q.delete();
    end_q.delete();
    len_q.delete();
    ovl_q.delete();
    env_first = 0;
    st8_idle = 1'b0;
    st9_idle = 1'b0;
    quiet_after_rst = 1'b0;
    for (int k = -8; k <= last; k++) begin
      @(negedge clk);
      if (k == -4) begin
        rst_env   = int'(bus.envelope);
        rst_start = int'(bus.burst_start);
        rst_end   = int'(bus.burst_end);
        rst_ovl   = int'(bus.overlength);
        rst_len   = int'(bus.burst_len);
      end
      if (k >= -4) begin
        if (bus.burst_start) start_q.push_back(k);
        if (bus.burst_end) begin
          end_q.push_back(k);
          len_q.push_back(int'(bus.burst_len));
          ovl_q.push_back(int'(bus.overlength));
        end
        if (bus.envelope && end_q.size() == 0) env_first++;
        if (k == 8) st8_idle = (dut.state == S_IDLE);
        if (k == 9) st9_idle = (dut.state == S_IDLE);
        if (k == reset_at + 1)
          quiet_after_rst = !(bus.envelope || bus.burst_start || bus.burst_end || bus.overlength)
                            && (bus.burst_len == '0);
      end
      n_reset = !((k < -5) || (k == reset_at));
      bus.in  = glitch ? ((k == -2) || (k == -1))
                       : (seg_on(k, s0, n0) || seg_on(k, s1, n1) || seg_on(k, s2, n2));
    end
  endtask

  initial begin
    bus.in = 1'b0;

    // 12 carrier cycles: normal qualified burst
    run_scn(0, 12, 0, 0, 0, 0, -100, 1'b0, 100);
    check("rst_envelope", rst_env, 0);
    check("rst_burst_start", rst_start, 0);
    check("rst_burst_end", rst_end, 0);
    check("rst_overlength", rst_ovl, 0);
    check("rst_burst_len", rst_len, 0);
    check("a_start_count", start_q.size(), 1);
    check("a_start_t", get(start_q, 0), 19);
    check("a_end_t", get(end_q, 0), 75);
    check("a_len", get(len_q, 0), 56);
    check("a_ovl", get(ovl_q, 0), 0);
    check("a_env_clocks", env_first, 56);

    // 3 carrier cycles: rejected
    run_scn(0, 3, 0, 0, 0, 0, -100, 1'b0, 60);
    check("b_start_count", start_q.size(), 0);
    check("b_end_count", end_q.size(), 0);
    check("b_env_clocks", env_first, 0);

    // 40 carrier cycles: cut at MAX_BURST
    run_scn(0, 40, 0, 0, 0, 0, -100, 1'b0, 260);
    check("c_start_t", get(start_q, 0), 19);
    check("c_end_t", get(end_q, 0), 181);
    check("c_len", get(len_q, 0), 162);
    check("c_ovl", get(ovl_q, 0), 1);
    check("c_env_clocks", env_first, 162);

    // Restart inside holdoff is ignored; restart after holdoff qualifies
    run_scn(0, 12, 77, 2, 89, 12, -100, 1'b0, 200);
    check("d_end0_t", get(end_q, 0), 75);
    check("d_start_count", start_q.size(), 2);
    check("d_start1_t", get(start_q, 1), 108);
    check("d_end1_t", get(end_q, 1), 164);
    check("d_len1", get(len_q, 1), 56);

    // Reset mid-burst at t=30
    run_scn(0, 12, 0, 0, 0, 0, 30, 1'b0, 100);
    check("e_quiet_t31", int'(quiet_after_rst), 1);
    check("e_start0_t", get(start_q, 0), 19);
    check("e_start1_t", get(start_q, 1), 55);
    check("e_end_count", end_q.size(), 1);
    check("e_end0_t", get(end_q, 0), 75);
    check("e_len0", get(len_q, 0), 20);

    // Single 2-clock glitch
    run_scn(0, 0, 0, 0, 0, 0, -100, 1'b1, 40);
    check("f_start_count", start_q.size(), 0);
    check("f_end_count", end_q.size(), 0);
    check("f_idle_t8", int'(st8_idle), 0);
    check("f_idle_t9", int'(st9_idle), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/burst_detect.md
BURST_DETECT -- requirements
Module: burst_detect

Interface
REQ-001 SHALL have parameter CLKS_PER_PERIOD, default 6, clocks per modulation-carrier period (81 MHz / 13.5 MHz).
REQ-002 SHALL have parameter MIN_EDGES, default 4, carrier rising edges needed to qualify a burst.
REQ-003 SHALL have parameter GAP_TIMEOUT, default 9, strobe-free clocks that end a burst; legal values are greater than CLKS_PER_PERIOD.
REQ-004 SHALL have parameter MAX_BURST, default 162, maximum envelope length in clocks (2 us).
REQ-005 SHALL have parameter HOLDOFF, default 12, clocks during which edges are ignored after a burst ends.
REQ-006 SHALL derive LEN_WIDTH = $clog2(MAX_BURST+1).
REQ-007 clk  input  1  single system clock; all logic on its rising edge.
REQ-008 n_reset  input  1  synchronous, active-low reset.
REQ-009 in  input  1  asynchronous modulated carrier from the receiver front end.
REQ-010 envelope  output  1  high while a qualified burst is active; drives the downstream delay-line input.
REQ-011 burst_start  output  1  one-clock pulse in the first envelope-high cycle.
REQ-012 burst_end  output  1  one-clock pulse in the first cycle after envelope falls.
REQ-013 burst_len  output  LEN_WIDTH  count of envelope-high clocks; updated and held from the burst_end cycle.
REQ-014 overlength  output  1  one-clock pulse, coincident with burst_end, when the burst was cut at MAX_BURST.

Function
REQ-015 in SHALL pass through two synchronising flip-flops; a strobe SHALL fire in each cycle where the synchronised value is 1 and its previous value was 0.
REQ-016 The FSM SHALL have states IDLE, QUALIFY, ACTIVE and HOLDOFF.
REQ-017 IDLE: a strobe SHALL move the FSM to QUALIFY with edge_cnt=1 and gap_ctr=0.
REQ-018 gap_ctr SHALL clear on a strobe and otherwise increment, saturating at GAP_TIMEOUT.
REQ-019 QUALIFY: each strobe SHALL increment edge_cnt; the strobe that makes edge_cnt equal MIN_EDGES SHALL move the FSM to ACTIVE.
REQ-020 envelope and burst_start SHALL rise in the cycle after that qualifying strobe.
REQ-021 QUALIFY: reaching GAP_TIMEOUT SHALL return the FSM to IDLE with no output activity (rejected burst).
REQ-022 ACTIVE: with the last strobe at cycle t, envelope SHALL fall, and burst_end pulse, at cycle t+GAP_TIMEOUT; the FSM SHALL then move to HOLDOFF.
REQ-023 The length counter SHALL count envelope-high cycles; when it reaches MAX_BURST, the next cycle SHALL drop envelope and pulse burst_end and overlength together; the FSM SHALL then move to HOLDOFF.
REQ-024 If a timeout and MAX_BURST occur in the same cycle, overlength SHALL take precedence.
REQ-025 HOLDOFF SHALL last exactly HOLDOFF cycles, then return to IDLE; strobes during HOLDOFF, including its last cycle, SHALL be ignored.
REQ-026 All outputs SHALL be registered; burst_len SHALL hold its value until the next burst_end.

Reset
REQ-027 n_reset=0 at a clock edge SHALL force IDLE, clear all counters and synchroniser flops, and set envelope, burst_start, burst_end, overlength and burst_len to 0 from the next cycle.
REQ-028 Reset during ACTIVE SHALL NOT produce a burst_end pulse.

Structure
REQ-029 CLK_FREQ (81_000_000), MODULATION_FREQ (13_500_000) and the FSM state encodings SHALL live in the shared delay-line constants package, with CLKS_PER_PERIOD derived from them there.
REQ-030 The two-flop synchroniser SHALL be a separate sub-module, sync_ff, reusable by the top level.

Verification
(All scenarios use a carrier with a 6-clock period and 50 % duty, and measure times from the first strobe at t=0.)
REQ-031 12 carrier cycles: expect burst_start and envelope rise at t=19, burst_end at t=75, burst_len=56, overlength=0.
REQ-032 3 carrier cycles only: expect envelope, burst_start and burst_end to stay 0 throughout.
REQ-033 Continuous carrier of 40 cycles: expect envelope high for exactly 162 clocks, burst_end=overlength=1 in the same cycle, burst_len=162.
REQ-034 Carrier restarting 2 clocks after burst_end: expect those edges ignored; a restart 14 clocks after burst_end expects a new burst_start 19 clocks after its first strobe.
REQ-035 n_reset pulled low for 1 cycle at t=30 of a 12-cycle burst: expect all outputs 0 from t=31, no burst_end, and no new burst_start until after 4 further strobes.
REQ-036 Single 2-clock glitch on in: expect no outputs, and the FSM back in IDLE 9 clocks after the strobe.
